// File: rtl/ddr3_arb_pkg.sv
// Shared constants and types for the two-master DDR3 EMIF arbiter.
// Optional statistics are enabled with the DDR3_ARB_STATS_EN macro (see ddr3_emif_arbiter).
package ddr3_arb_pkg;

    localparam int ADDR_W    = 25;
    localparam int DATA_W    = 256;
    localparam int BE_W      = DATA_W / 8;
    localparam int BURST_W   = 5;
    localparam int TAG_DEPTH = 16;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        CMD    = 2'd1,
        WBURST = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic               id;
        logic [BURST_W-1:0] burst;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    // A zero burstcount is serviced as a single beat.
    function automatic logic [BURST_W-1:0] burst_norm(input logic [BURST_W-1:0] b);
        return (b == '0) ? BURST_W'(1) : b;
    endfunction

endpackage

// File: rtl/ddr3_arb_tag_fifo.sv
// Show-ahead synchronous FIFO holding {master id, burst} for every read in flight.
// Push and pop in the same cycle are both honoured and leave the count unchanged.
module ddr3_arb_tag_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (do_push ? PTR_W'(1) : PTR_W'(0));
        rd_ptr_d = rd_ptr_q + (do_pop ? PTR_W'(1) : PTR_W'(0));
        count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ddr3_emif_arbiter.sv
// Round-robin arbiter sharing one DDR3 EMIF Avalon-MM port between m0 and m1, with write-burst lock
// and in-order read return routing. Define DDR3_ARB_STATS_EN for command/wait counters and orphan flag.
module ddr3_emif_arbiter
    import ddr3_arb_pkg::*;
(
    input  logic               ddr3_emif_clk,
    input  logic               ddr3_emif_rst_n,
    input  logic               m0_read,
    input  logic               m0_write,
    input  logic [ADDR_W-1:0]  m0_addr,
    input  logic [BURST_W-1:0] m0_burst_count,
    input  logic [DATA_W-1:0]  m0_write_data,
    input  logic [BE_W-1:0]    m0_byte_enable,
    output logic               m0_waitrequest,
    output logic [DATA_W-1:0]  m0_read_data,
    output logic               m0_read_data_valid,
    input  logic               m1_read,
    input  logic               m1_write,
    input  logic [ADDR_W-1:0]  m1_addr,
    input  logic [BURST_W-1:0] m1_burst_count,
    input  logic [DATA_W-1:0]  m1_write_data,
    input  logic [BE_W-1:0]    m1_byte_enable,
    output logic               m1_waitrequest,
    output logic [DATA_W-1:0]  m1_read_data,
    output logic               m1_read_data_valid,
    input  logic               ddr3_emif_ready,
    output logic               ddr3_emif_read,
    output logic               ddr3_emif_write,
    output logic [ADDR_W-1:0]  ddr3_emif_addr,
    output logic [DATA_W-1:0]  ddr3_emif_write_data,
    output logic [BE_W-1:0]    ddr3_emif_byte_enable,
    output logic [BURST_W-1:0] ddr3_emif_burst_count,
    input  logic [DATA_W-1:0]  ddr3_emif_read_data,
    input  logic               ddr3_emif_rddata_valid,
    output arb_state_e         dbg_state
`ifdef DDR3_ARB_STATS_EN
    ,
    output logic [31:0]        stat_cmd_cnt0,
    output logic [31:0]        stat_cmd_cnt1,
    output logic [31:0]        stat_wait_cnt,
    output logic               stat_err
`endif
);

    arb_state_e         state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [BURST_W-1:0] wbeats_q, wbeats_d;
    logic [BURST_W-1:0] rbeats_q, rbeats_d;

    logic               sel_read, sel_write;
    logic [BURST_W-1:0] sel_burst_n;
    logic               busy, cmd_read, cmd_write, accept;
    logic               elig0, elig1;

    tag_t               push_tag, head_tag;
    logic [TAG_W-1:0]   head_raw;
    logic               tag_push, tag_pop, tag_full, tag_empty;
    logic [BURST_W-1:0] rd_cur;
    logic               rd_hit;

    assign sel_read    = grant_q ? m1_read  : m0_read;
    assign sel_write   = grant_q ? m1_write : m0_write;
    assign sel_burst_n = burst_norm(grant_q ? m1_burst_count : m0_burst_count);

    assign busy      = (state_q == CMD) || (state_q == WBURST);
    assign cmd_write = busy & sel_write;
    assign cmd_read  = (state_q == CMD) & sel_read & ~sel_write;
    assign accept    = ddr3_emif_ready & (cmd_read | cmd_write);

    assign ddr3_emif_read        = cmd_read;
    assign ddr3_emif_write       = cmd_write;
    assign ddr3_emif_addr        = grant_q ? m1_addr        : m0_addr;
    assign ddr3_emif_write_data  = grant_q ? m1_write_data  : m0_write_data;
    assign ddr3_emif_byte_enable = grant_q ? m1_byte_enable : m0_byte_enable;
    assign ddr3_emif_burst_count = sel_burst_n;

    assign m0_waitrequest = ~(busy & ~grant_q & ddr3_emif_ready);
    assign m1_waitrequest = ~(busy &  grant_q & ddr3_emif_ready);

    // Reads are only eligible while a tag slot is free to route their return.
    assign elig0 = m0_write | (m0_read & ~tag_full);
    assign elig1 = m1_write | (m1_read & ~tag_full);

    assign push_tag.id    = grant_q;
    assign push_tag.burst = sel_burst_n;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wbeats_d     = wbeats_q;
        tag_push     = 1'b0;
        case (state_q)
            ARB: begin
                if (elig0 | elig1) begin
                    state_d = CMD;
                    grant_d = (elig0 & elig1) ? ~last_grant_q : elig1;
                end
            end
            CMD: begin
                if (!(cmd_read | cmd_write)) begin
                    state_d = ARB;
                end else if (accept) begin
                    if (cmd_read) begin
                        tag_push     = 1'b1;
                        state_d      = ARB;
                        last_grant_d = grant_q;
                    end else if (sel_burst_n == BURST_W'(1)) begin
                        state_d      = ARB;
                        last_grant_d = grant_q;
                    end else begin
                        wbeats_d = sel_burst_n - BURST_W'(1);
                        state_d  = WBURST;
                    end
                end
            end
            WBURST: begin
                if (accept) begin
                    wbeats_d = wbeats_q - BURST_W'(1);
                    if (wbeats_q == BURST_W'(1)) begin
                        state_d      = ARB;
                        last_grant_d = grant_q;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    // rbeats_q == 0 means the head tag's burst has not been loaded yet.
    assign head_tag = head_raw;
    assign rd_cur   = (rbeats_q == '0) ? head_tag.burst : rbeats_q;
    assign rd_hit   = ddr3_emif_rddata_valid & ~tag_empty;
    assign tag_pop  = rd_hit & (rd_cur == BURST_W'(1));

    always_comb begin
        rbeats_d = rbeats_q;
        if (rd_hit) begin
            rbeats_d = tag_pop ? '0 : rd_cur - BURST_W'(1);
        end
    end

    assign m0_read_data       = ddr3_emif_read_data;
    assign m1_read_data       = ddr3_emif_read_data;
    assign m0_read_data_valid = rd_hit & ~head_tag.id;
    assign m1_read_data_valid = rd_hit &  head_tag.id;

    always_ff @(posedge ddr3_emif_clk) begin
        if (!ddr3_emif_rst_n) begin
            state_q      <= ARB;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wbeats_q     <= '0;
            rbeats_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wbeats_q     <= wbeats_d;
            rbeats_q     <= rbeats_d;
        end
    end

    assign dbg_state = state_q;

    ddr3_arb_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (ddr3_emif_clk),
        .rst_n     (ddr3_emif_rst_n),
        .push      (tag_push),
        .push_data (push_tag),
        .pop       (tag_pop),
        .head      (head_raw),
        .full      (tag_full),
        .empty     (tag_empty)
    );

`ifdef DDR3_ARB_STATS_EN
    logic [31:0] cmd_cnt0_q, cmd_cnt0_d;
    logic [31:0] cmd_cnt1_q, cmd_cnt1_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;
    logic        cmd_accept, any_stall;

    assign cmd_accept = (state_q == CMD) & accept;
    assign any_stall  = ((m0_read | m0_write) & m0_waitrequest) |
                        ((m1_read | m1_write) & m1_waitrequest);

    always_comb begin
        cmd_cnt0_d = cmd_cnt0_q + ((cmd_accept & ~grant_q) ? 32'd1 : 32'd0);
        cmd_cnt1_d = cmd_cnt1_q + ((cmd_accept &  grant_q) ? 32'd1 : 32'd0);
        wait_cnt_d = wait_cnt_q + (any_stall ? 32'd1 : 32'd0);
        err_d      = err_q | (ddr3_emif_rddata_valid & tag_empty);
    end

    always_ff @(posedge ddr3_emif_clk) begin
        if (!ddr3_emif_rst_n) begin
            cmd_cnt0_q <= '0;
            cmd_cnt1_q <= '0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            cmd_cnt0_q <= cmd_cnt0_d;
            cmd_cnt1_q <= cmd_cnt1_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign stat_cmd_cnt0 = cmd_cnt0_q;
    assign stat_cmd_cnt1 = cmd_cnt1_q;
    assign stat_wait_cnt = wait_cnt_q;
    assign stat_err      = err_q;
`endif

endmodule

// File: tb/tb_ddr3_emif_arbiter.sv
// Directed bench for ddr3_emif_arbiter: arbitration order, burst lock, tag-full stall,
// read routing, reset abort. Build with DDR3_ARB_STATS_EN to also check the counters.
module tb_ddr3_emif_arbiter;
    import ddr3_arb_pkg::*;

    localparam int TIMEOUT = 300;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic               m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
    logic [ADDR_W-1:0]  m0_addr = '0, m1_addr = '0;
    logic [BURST_W-1:0] m0_burst_count = '0, m1_burst_count = '0;
    logic [DATA_W-1:0]  m0_write_data = '0, m1_write_data = '0;
    logic [BE_W-1:0]    m0_byte_enable = '0, m1_byte_enable = '0;
    logic               m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0]  m0_read_data, m1_read_data;
    logic               m0_read_data_valid, m1_read_data_valid;
    logic               ddr3_emif_ready = 1'b1;
    logic               ddr3_emif_read, ddr3_emif_write;
    logic [ADDR_W-1:0]  ddr3_emif_addr;
    logic [DATA_W-1:0]  ddr3_emif_write_data;
    logic [BE_W-1:0]    ddr3_emif_byte_enable;
    logic [BURST_W-1:0] ddr3_emif_burst_count;
    logic [DATA_W-1:0]  ddr3_emif_read_data = '0;
    logic               ddr3_emif_rddata_valid = 1'b0;
    arb_state_e         dbg_state;
`ifdef DDR3_ARB_STATS_EN
    logic [31:0]        stat_cmd_cnt0, stat_cmd_cnt1, stat_wait_cnt;
    logic               stat_err;
`endif

    ddr3_emif_arbiter dut (
        .ddr3_emif_clk          (clk),
        .ddr3_emif_rst_n        (rst_n),
        .m0_read                (m0_read),
        .m0_write               (m0_write),
        .m0_addr                (m0_addr),
        .m0_burst_count         (m0_burst_count),
        .m0_write_data          (m0_write_data),
        .m0_byte_enable         (m0_byte_enable),
        .m0_waitrequest         (m0_waitrequest),
        .m0_read_data           (m0_read_data),
        .m0_read_data_valid     (m0_read_data_valid),
        .m1_read                (m1_read),
        .m1_write               (m1_write),
        .m1_addr                (m1_addr),
        .m1_burst_count         (m1_burst_count),
        .m1_write_data          (m1_write_data),
        .m1_byte_enable         (m1_byte_enable),
        .m1_waitrequest         (m1_waitrequest),
        .m1_read_data           (m1_read_data),
        .m1_read_data_valid     (m1_read_data_valid),
        .ddr3_emif_ready        (ddr3_emif_ready),
        .ddr3_emif_read         (ddr3_emif_read),
        .ddr3_emif_write        (ddr3_emif_write),
        .ddr3_emif_addr         (ddr3_emif_addr),
        .ddr3_emif_write_data   (ddr3_emif_write_data),
        .ddr3_emif_byte_enable  (ddr3_emif_byte_enable),
        .ddr3_emif_burst_count  (ddr3_emif_burst_count),
        .ddr3_emif_read_data    (ddr3_emif_read_data),
        .ddr3_emif_rddata_valid (ddr3_emif_rddata_valid),
        .dbg_state              (dbg_state)
`ifdef DDR3_ARB_STATS_EN
        ,
        .stat_cmd_cnt0          (stat_cmd_cnt0),
        .stat_cmd_cnt1          (stat_cmd_cnt1),
        .stat_wait_cnt          (stat_wait_cnt),
        .stat_err               (stat_err)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    bit abort = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // EMIF-side log of accepted commands/beats and master-side read return log.
    bit          log_rd[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_burst[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];
    bit          rv_id[$];
    logic [31:0] rv_data[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (ddr3_emif_ready && (ddr3_emif_read || ddr3_emif_write)) begin
                log_rd.push_back(ddr3_emif_read);
                log_addr.push_back(32'(ddr3_emif_addr));
                log_burst.push_back(32'(ddr3_emif_burst_count));
                log_data.push_back(ddr3_emif_write_data[31:0]);
                log_cyc.push_back(cyc);
            end
            if (m0_read_data_valid) begin
                rv_id.push_back(1'b0);
                rv_data.push_back(m0_read_data[31:0]);
            end
            if (m1_read_data_valid) begin
                rv_id.push_back(1'b1);
                rv_data.push_back(m1_read_data[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] wpat(input int m, input int beat);
        return 32'hA000_0000 | (32'(m) << 16) | 32'(beat);
    endfunction

    task automatic drive_master(input int m, input logic rd, input logic wr,
                                input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] b,
                                input logic [31:0] d);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_addr = a; m0_burst_count = b;
            m0_write_data = {8{d}}; m0_byte_enable = '1;
        end else begin
            m1_read = rd; m1_write = wr; m1_addr = a; m1_burst_count = b;
            m1_write_data = {8{d}}; m1_byte_enable = '1;
        end
    endtask

    function automatic logic get_wait(input int m);
        return (m == 0) ? m0_waitrequest : m1_waitrequest;
    endfunction

    // One command (all beats for a write); waits counts negedges seen with waitrequest=1.
    task automatic master_cmd(input int m, input bit is_wr, input logic [ADDR_W-1:0] a,
                              input logic [BURST_W-1:0] b, output int waits);
        int beats;
        int n;
        bit done;
        beats = is_wr ? int'(burst_norm(b)) : 1;
        waits = 0;
        @(posedge clk); #1;
        for (int i = 0; i < beats; i++) begin
            drive_master(m, !is_wr, is_wr, a, b, wpat(m, i));
            n = 0;
            done = 0;
            while (!done) begin
                @(negedge clk);
                if (abort) begin
                    drive_master(m, 0, 0, '0, '0, '0);
                    return;
                end
                if (!get_wait(m)) done = 1;
                else begin
                    waits++;
                    n++;
                    if (n > TIMEOUT) begin
                        check($sformatf("timeout_m%0d", m), 64'(n), 64'(TIMEOUT));
                        drive_master(m, 0, 0, '0, '0, '0);
                        return;
                    end
                end
            end
            @(posedge clk); #1;
        end
        drive_master(m, 0, 0, '0, '0, '0);
    endtask

    task automatic emif_return(input int n, input logic [31:0] base);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            ddr3_emif_rddata_valid = 1'b1;
            ddr3_emif_read_data = {8{base + 32'(i)}};
            @(posedge clk); #1;
        end
        ddr3_emif_rddata_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive_master(0, 0, 0, '0, '0, '0);
        drive_master(1, 0, 0, '0, '0, '0);
        ddr3_emif_ready = 1'b1;
        ddr3_emif_rddata_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_writes(input int base, input int target);
        int n;
        n = 0;
        while (log_rd.size() - base < target && n < TIMEOUT) begin
            @(negedge clk); #1;
            n++;
        end
        check("wait_writes_bound", 64'(log_rd.size() - base >= target), 64'd1);
    endtask

    // ---------------- directed tests ----------------
    int w0, w1, wb, lb, rb;

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_m0_wait", m0_waitrequest, 1);
        check("rst_m1_wait", m1_waitrequest, 1);
        check("rst_emif_rd", ddr3_emif_read, 0);
        check("rst_emif_wr", ddr3_emif_write, 0);
        check("rst_state", dbg_state, ARB);
        check("rst_rdv", {m0_read_data_valid, m1_read_data_valid}, 0);

        // Lone m0 read burst 4, then 4 return beats to m0
        lb = log_rd.size(); rb = rv_id.size();
        master_cmd(0, 0, 25'h100, 5'd4, w0);
        check("t1_wait", w0, 1);
        check("t1_ncmd", log_rd.size() - lb, 1);
        check("t1_is_rd", log_rd[lb], 1);
        check("t1_addr", log_addr[lb], 32'h100);
        check("t1_burst", log_burst[lb], 4);
`ifdef DDR3_ARB_STATS_EN
        check("t1_stat_cnt0", stat_cmd_cnt0, 1);
        check("t1_stat_wait", stat_wait_cnt, 1);
`endif
        emif_return(4, 32'h1000);
        @(negedge clk);
        check("t1_nbeats", rv_id.size() - rb, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_id%0d", i), rv_id[rb+i], 0);
            check($sformatf("t1_data%0d", i), rv_data[rb+i], 32'h1000 + 32'(i));
        end

        // Tie after reset: m0 read first, then m1 8-beat write back to back
        do_reset();
        lb = log_rd.size();
        fork
            master_cmd(0, 0, 25'h200, 5'd2, w0);
            master_cmd(1, 1, 25'h300, 5'd8, w1);
        join
        check("t2_ncmd", log_rd.size() - lb, 9);
        check("t2_first_rd", log_rd[lb], 1);
        check("t2_first_addr", log_addr[lb], 32'h200);
        check("t2_w1_wait", w1, 3);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(wpat(1, i));
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_wr%0d", i), {log_rd[lb+1+i], log_data[lb+1+i]},
                  {1'b0, exp_q.pop_front()});
        end
        check("t2_consecutive", log_cyc[lb+8] - log_cyc[lb+1], 7);
        emif_return(2, 32'h2000);
        lb = log_rd.size();
        fork
            master_cmd(0, 0, 25'h210, 5'd1, w0);
            master_cmd(1, 0, 25'h310, 5'd1, w1);
        join
        check("t2_tie_first", log_addr[lb], 32'h210);
        check("t2_tie_second", log_addr[lb+1], 32'h310);

        // Ready low 5 cycles at beat 3 of 8; m0 read waits for the burst
        do_reset();
        lb = log_rd.size();
        fork
            master_cmd(1, 1, 25'h400, 5'd8, w1);
            begin
                wait_writes(lb, 2);
                @(posedge clk); #1;
                ddr3_emif_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("t3_stall_wait", m1_waitrequest, 1);
                    check("t3_stall_state", dbg_state, WBURST);
                end
                @(posedge clk); #1;
                ddr3_emif_ready = 1'b1;
            end
            begin
                repeat (4) @(posedge clk);
                master_cmd(0, 0, 25'h410, 5'd1, w0);
            end
        join
        check("t3_w1_wait", w1, 6);
        check("t3_ncmd", log_rd.size() - lb, 9);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(wpat(1, i));
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_wr%0d", i), {log_rd[lb+i], log_data[lb+i]},
                  {1'b0, exp_q.pop_front()});
        end
        check("t3_rd_after", {log_rd[lb+8], log_addr[lb+8]}, {1'b1, 32'h410});

        // 16 reads fill the tags; 17th stalls, m1 write still goes; a return frees a slot
        do_reset();
        lb = log_rd.size(); rb = rv_id.size();
        for (int i = 0; i < 16; i++) master_cmd(0, 0, 25'h500 + 25'(i), 5'd1, w0);
        check("t4_nreads", log_rd.size() - lb, 16);
        fork
            master_cmd(0, 0, 25'h600, 5'd1, w0);
            begin
                repeat (10) @(negedge clk);
                check("t4_stall_wait", m0_waitrequest, 1);
                check("t4_stall_ncmd", log_rd.size() - lb, 16);
                master_cmd(1, 1, 25'h700, 5'd1, wb);
                check("t4_wr_wait", wb, 1);
                check("t4_wr_logged", {log_rd[lb+16], log_addr[lb+16]}, {1'b0, 32'h700});
                emif_return(1, 32'h4000);
            end
        join
        check("t4_ncmd", log_rd.size() - lb, 18);
        check("t4_rd17", {log_rd[lb+17], log_addr[lb+17]}, {1'b1, 32'h600});
        check("t4_ret_id", {rv_id.size() - rb, rv_id[rb]}, {32'd1, 1'b0});

        // Burst 0 write is one beat; interleaved reads route in issue order
        do_reset();
        lb = log_rd.size(); rb = rv_id.size();
        master_cmd(1, 1, 25'h800, 5'd0, w1);
        @(negedge clk);
        check("t5_b0_ncmd", log_rd.size() - lb, 1);
        check("t5_b0_state", dbg_state, ARB);
        master_cmd(0, 0, 25'h900, 5'd2, w0);
        master_cmd(1, 0, 25'h910, 5'd3, w1);
        emif_return(5, 32'h3000);
        @(negedge clk);
        check("t5_nbeats", rv_id.size() - rb, 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t5_route%0d", i), rv_id[rb+i], (i < 2) ? 0 : 1);
        end
        check("t5_bcast_data", rv_data[rb+4], 32'h3004);
        // Pop of m0's tag in the same cycle m1's read pushes a new one
        rb = rv_id.size();
        master_cmd(0, 0, 25'h920, 5'd1, w0);
        fork
            master_cmd(1, 0, 25'h930, 5'd1, w1);
            begin
                @(posedge clk);
                emif_return(1, 32'h5000);
            end
        join
        emif_return(1, 32'h5001);
        @(negedge clk);
        check("t5_pp_route", {rv_id.size() - rb, rv_id[rb], rv_id[rb+1]}, {32'd2, 1'b0, 1'b1});

        // Reset at beat 4 of 8 aborts the burst and drops outstanding tags
        do_reset();
        lb = log_rd.size();
        master_cmd(0, 0, 25'hB00, 5'd1, w0);
        fork
            master_cmd(1, 1, 25'hC00, 5'd8, w1);
            begin
                wait_writes(lb, 4);
                @(posedge clk); #1;
                rst_n = 1'b0;
                abort = 1;
                @(posedge clk);
                @(negedge clk);
                check("t6_emif_wr", ddr3_emif_write, 0);
                check("t6_state", dbg_state, ARB);
                check("t6_m1_wait", m1_waitrequest, 1);
            end
        join
        abort = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_emif_wr_post", ddr3_emif_write, 0);
        check("t6_wbeats", log_rd.size() - lb, 4);
`ifdef DDR3_ARB_STATS_EN
        check("t6_stat_cnt0", stat_cmd_cnt0, 0);
        check("t6_stat_cnt1", stat_cmd_cnt1, 0);
        check("t6_stat_wait", stat_wait_cnt, 0);
        check("t6_stat_err0", stat_err, 0);
`endif
        rb = rv_id.size();
        emif_return(1, 32'h6000);
        @(negedge clk);
        check("t6_orphan_dropped", rv_id.size() - rb, 0);
`ifdef DDR3_ARB_STATS_EN
        check("t6_stat_err1", stat_err, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
